ad7476_spi_responder: RTL and testbench
=======================================

Name: ad7476_spi_responder

Overview:
- SPI responder that emulates an AD7476 12-bit ADC on CSn/SCLK/SDATA, for loopback and bench test of the fabric ADC interface.
- Firmware or test logic pushes 12-bit samples into an internal FIFO.
- On each CSn-low frame the block shifts out 4 leading zeros, then the 12-bit sample MSB first, changing data on SCLK falling edges.
- Everything runs on the single fabric clock; CSn and SCLK are asynchronous inputs that the block synchronises and edge-detects.

Parameters:
- DATA_W, 12: sample width.
- LEAD_ZEROS, 4: leading zero bits per frame. Frame length FRAME_W = LEAD_ZEROS + DATA_W = 16.
- FIFO_ADDR_W, 3: FIFO depth is 2**FIFO_ADDR_W = 8.
- SYNC_STAGES, 2: flops in the CSn/SCLK synchronisers (minimum 2).

Ports:
- clk_i, input, 1: fabric clock. Must be at least 8x the SCLK frequency.
- rst_i, input, 1: synchronous reset, active-low.
- enable_i, input, 1: responder enable.
- sample_dat_i, input, DATA_W: sample to enqueue.
- sample_push_i, input, 1: one-cycle enqueue strobe.
- fifo_full_o, output, 1: FIFO full.
- fifo_level_o, output, FIFO_ADDR_W+1: FIFO occupancy.
- spi_ss_i, input, 1: CSn from the master, active-low, asynchronous.
- spi_sck_i, input, 1: SCLK from the master, asynchronous.
- spi_miso_o, output, 1: SDATA to the master.
- spi_miso_oe_o, output, 1: SDATA drive enable (tristate control).
- frame_done_o, output, 1: one-cycle pulse when a full 16-bit frame completes.
- frame_abort_o, output, 1: one-cycle pulse when CSn rises mid-frame.
- overflow_o, output, 1: sticky; a push was dropped.
- underrun_o, output, 1: sticky; a frame started with the FIFO empty.
- status_clr_i, input, 1: clears overflow_o and underrun_o.
- frame_cnt_o, output, 16: count of completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_i low at a clk_i edge):
  - state IDLE, FIFO empty, shift register 0, bit counter 0, last-sample register 0.
  - All outputs 0: fifo_level_o = 0, fifo_full_o = 0, and every pulse, sticky flag and counter cleared.
  - A reset mid-frame releases SDATA (oe = 0) on the next cycle.
- Synchronisers and edge detect:
  - SYNC_STAGES flops, then one history flop per line.
  - ss_fall, ss_rise and sck_fall are single-cycle detects on the synchronised signals.
- FIFO:
  - A push is accepted if not full, or if a pop happens in the same cycle.
  - A push into a full FIFO with no pop is dropped, sets overflow_o, and leaves data unchanged.
  - Pointers wrap modulo the depth. fifo_level_o is exact: 0 to 8.
- State IDLE:
  - spi_miso_oe_o = 0, spi_miso_o = 0.
  - On ss_fall with enable_i = 1, go to SHIFT.
  - If the FIFO is not empty, pop the head into the shift register's low DATA_W bits, zero the upper LEAD_ZEROS bits, and update the last-sample register.
  - If the FIFO is empty, load the last-sample register instead and set underrun_o.
  - Set the bit counter to FRAME_W-1.
  - The same cycle drives oe = 1 and miso = shift[FRAME_W-1], which is 0.
  - Latency from the CSn pin falling to SDATA driven: SYNC_STAGES+2 clk_i cycles at most.
- State SHIFT:
  - On each sck_fall, shift left by one and decrement the counter. miso always reflects shift[FRAME_W-1].
  - On the sck_fall seen with counter = 0 (the 16th falling edge): pulse frame_done_o, increment frame_cnt_o, set oe = 0, go to DONE.
  - On ss_rise before that edge: pulse frame_abort_o, set oe = 0, go to IDLE. The popped sample is consumed, not re-queued.
- State DONE: oe = 0. Extra SCLK edges are ignored. On ss_rise, go to IDLE.
- Edge-case rules:
  - sck_fall while CSn is high is ignored.
  - ss_fall and sck_fall in the same cycle: only the frame start is processed; that SCLK edge is ignored.
  - If enable_i goes low in SHIFT or DONE, the current frame finishes normally; no new frame starts until enable_i = 1.
  - Pushes are accepted regardless of enable_i.
  - status_clr_i and a set event in the same cycle: the set wins.

Decomposition:
- Shared package `ad7476_resp_pkg`:
  - state enum {IDLE, SHIFT, DONE}
  - FRAME_W and LEAD_ZEROS constants
  - width of the 16-bit frame counter
- Sub-module `ad7476_resp_fifo`: synchronous FIFO with push, pop, full, empty, level and simultaneous push/pop handling.
- Synchronisers, edge detect, FSM and shifter stay in the top module.

Test Plan:
- Push 0xABC, then one 16-SCLK frame -> master samples 0000_1010_1011_1100; frame_done_o pulses once; frame_cnt_o = 1; oe = 0 after the 16th falling edge.
- Push 0x123 and 0xFFF, then two frames -> 0x0123 then 0x0FFF; fifo_level_o goes 2 -> 1 -> 0; underrun_o stays 0.
- Frame with the FIFO empty after last sample 0xFFF -> 0x0FFF repeated; underrun_o = 1; status_clr_i pulse -> underrun_o = 0.
- Push 9 samples 0x001 to 0x009 with no frames -> fifo_full_o = 1, level = 8, overflow_o = 1; following frames return 0x001 to 0x008.
- CSn rises after 7 SCLKs on sample 0x555 -> frame_abort_o pulses, frame_cnt_o unchanged, oe = 0; the next frame returns the next FIFO entry.
- Reset asserted mid-frame (after 5 SCLKs) -> next cycle oe = 0, level = 0, frame_cnt_o = 0, all flags 0.

Source files
------------

// File: rtl/ad7476_resp_pkg.sv
// Shared state type and frame constants for the AD7476 SPI responder.
package ad7476_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int LEAD_ZEROS  = 4;
  localparam int FRAME_W     = LEAD_ZEROS + 12;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/ad7476_resp_fifo.sv
// Sample FIFO with first-word-fall-through head, exact level and drop flag.
module ad7476_resp_fifo #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              drop_o
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int LEVEL_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   level_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (level_reg == LEVEL_W'(DEPTH));
  assign empty_o = (level_reg == '0);
  assign level_o = level_reg;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;

  // The frame start needs the head in the same cycle it pops, hence the direct read.
  assign head_o = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level_reg <= level_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level_reg <= level_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad7476_spi_responder.sv
// AD7476 ADC emulator: shifts queued 12-bit samples out on CSn/SCLK/SDATA,
// with CSn and SCLK synchronised into the fabric clock domain.
module ad7476_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int FIFO_ADDR_W = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  enable_i,
  input  logic [DATA_W-1:0]                     sample_dat_i,
  input  logic                                  sample_push_i,
  output logic                                  fifo_full_o,
  output logic [FIFO_ADDR_W:0]                  fifo_level_o,
  input  logic                                  spi_ss_i,
  input  logic                                  spi_sck_i,
  output logic                                  spi_miso_o,
  output logic                                  spi_miso_oe_o,
  output logic                                  frame_done_o,
  output logic                                  frame_abort_o,
  output logic                                  overflow_o,
  output logic                                  underrun_o,
  input  logic                                  status_clr_i,
  output logic [ad7476_resp_pkg::FRAME_CNT_W-1:0] frame_cnt_o
);

  import ad7476_resp_pkg::*;

  localparam int FRAME_W = LEAD_ZEROS + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  // Index 0 carries CSn, index 1 carries SCLK.
  logic [1:0] pin_w;
  logic [1:0] sync_w;
  logic [1:0] hist_w;

  assign pin_w = {spi_sck_i, spi_ss_i};

  // Both lines reset to their idle-high level so reset never fakes an edge.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_reg;
    logic                   hist_reg;

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        chain_reg <= '1;
        hist_reg  <= 1'b1;
      end else begin
        chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_w[gi]};
        hist_reg  <= chain_reg[SYNC_STAGES-1];
      end
    end

    assign sync_w[gi] = chain_reg[SYNC_STAGES-1];
    assign hist_w[gi] = hist_reg;
  end

  logic ss_fall;
  logic ss_rise;
  logic sck_fall;

  assign ss_fall  = hist_w[0] & ~sync_w[0];
  assign ss_rise  = ~hist_w[0] & sync_w[0];
  assign sck_fall = hist_w[1] & ~sync_w[1];

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_drop;

  ad7476_resp_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (sample_push_i),
    .push_dat_i (sample_dat_i),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full_o),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level_o),
    .drop_o     (fifo_drop)
  );

  state_t                   state_reg;
  state_t                   state_next;
  logic [FRAME_W-1:0]       shift_reg;
  logic [CNT_W-1:0]         bit_cnt_reg;
  logic [DATA_W-1:0]        last_sample_reg;
  logic                     frame_done_reg;
  logic                     frame_abort_reg;
  logic                     overflow_reg;
  logic                     underrun_reg;
  logic [FRAME_CNT_W-1:0]   frame_cnt_reg;

  logic frame_start;
  logic bit_shift;
  logic frame_end;
  logic frame_cut;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // CSn rising takes priority over a coincident SCLK edge: the master has left.
  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    bit_shift   = 1'b0;
    frame_end   = 1'b0;
    frame_cut   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall && enable_i) begin
          frame_start = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          frame_cut  = 1'b1;
          state_next = IDLE;
        end else if (sck_fall) begin
          bit_shift = 1'b1;
          if (bit_cnt_reg == '0) begin
            frame_end  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (ss_rise) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    spi_miso_oe_o = 1'b0;
    spi_miso_o    = 1'b0;
    if (state_reg == SHIFT) begin
      spi_miso_oe_o = 1'b1;
      spi_miso_o    = shift_reg[FRAME_W-1];
    end
  end

  assign fifo_pop = frame_start && !fifo_empty;

  // An empty FIFO replays the previous sample so the master still sees valid data.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      last_sample_reg <= '0;
    end else if (frame_start) begin
      shift_reg   <= {{LEAD_ZEROS{1'b0}}, (fifo_empty ? last_sample_reg : fifo_head)};
      bit_cnt_reg <= CNT_LAST;
      if (!fifo_empty) begin
        last_sample_reg <= fifo_head;
      end
    end else if (bit_shift) begin
      shift_reg   <= {shift_reg[FRAME_W-2:0], 1'b0};
      bit_cnt_reg <= bit_cnt_reg - 1'b1;
    end
  end

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      frame_done_reg  <= 1'b0;
      frame_abort_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      underrun_reg    <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      frame_done_reg  <= frame_end;
      frame_abort_reg <= frame_cut;
      if (frame_end) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
      if (fifo_drop) begin
        overflow_reg <= 1'b1;
      end else if (status_clr_i) begin
        overflow_reg <= 1'b0;
      end
      if (frame_start && fifo_empty) begin
        underrun_reg <= 1'b1;
      end else if (status_clr_i) begin
        underrun_reg <= 1'b0;
      end
    end
  end

  assign frame_done_o  = frame_done_reg;
  assign frame_abort_o = frame_abort_reg;
  assign overflow_o    = overflow_reg;
  assign underrun_o    = underrun_reg;
  assign frame_cnt_o   = frame_cnt_reg;

endmodule

// File: tb/tb_ad7476_spi_responder.sv
// Scoreboard bench for the AD7476 responder: bit-banged SPI master, queue of expected frames.
module tb_ad7476_spi_responder;

  localparam int HALF = 8;  // fabric cycles per SCLK half period

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [11:0] sample_dat_i = '0;
  logic        sample_push_i = 1'b0;
  logic        fifo_full_o;
  logic [3:0]  fifo_level_o;
  logic        spi_ss_i = 1'b1;
  logic        spi_sck_i = 1'b1;
  logic        spi_miso_o;
  logic        spi_miso_oe_o;
  logic        frame_done_o;
  logic        frame_abort_o;
  logic        overflow_o;
  logic        underrun_o;
  logic        status_clr_i = 1'b0;
  logic [15:0] frame_cnt_o;

  int          total = 0;
  int          bad = 0;
  int          done_seen = 0;
  int          abort_seen = 0;
  logic [15:0] exp_q[$];
  logic [11:0] mdl_last = '0;
  logic [15:0] mdl_cnt = '0;
  logic        mdl_ovf = 1'b0;
  logic        mdl_unr = 1'b0;

  ad7476_spi_responder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .sample_dat_i  (sample_dat_i),
    .sample_push_i (sample_push_i),
    .fifo_full_o   (fifo_full_o),
    .fifo_level_o  (fifo_level_o),
    .spi_ss_i      (spi_ss_i),
    .spi_sck_i     (spi_sck_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oe_o (spi_miso_oe_o),
    .frame_done_o  (frame_done_o),
    .frame_abort_o (frame_abort_o),
    .overflow_o    (overflow_o),
    .underrun_o    (underrun_o),
    .status_clr_i  (status_clr_i),
    .frame_cnt_o   (frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (frame_done_o) done_seen++;
    if (frame_abort_o) abort_seen++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push_sample(input logic [11:0] v);
    sample_dat_i  = v;
    sample_push_i = 1'b1;
    wait_clk(1);
    sample_push_i = 1'b0;
    if (exp_q.size() < 8) exp_q.push_back({4'h0, v});
    else mdl_ovf = 1'b1;
    $display("push 0x%03h model_level=%0d", v, exp_q.size());
  endtask

  task automatic clear_status();
    status_clr_i = 1'b1;
    wait_clk(1);
    status_clr_i = 1'b0;
    wait_clk(1);
    mdl_ovf = 1'b0;
    mdl_unr = 1'b0;
  endtask

  // Master samples SDATA just before each SCLK falling edge.
  task automatic shift_bits(input int n, output logic [15:0] word);
    word = '0;
    spi_ss_i = 1'b0;
    wait_clk(HALF);
    check_val("oe_on", {31'd0, spi_miso_oe_o}, 32'd1);
    for (int i = 0; i < n; i++) begin
      word = {word[14:0], spi_miso_o};
      spi_sck_i = 1'b0;
      wait_clk(HALF);
      spi_sck_i = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic next_expected(output logic [15:0] exp);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
    end else begin
      exp = {4'h0, mdl_last};
      mdl_unr = 1'b1;
    end
    mdl_last = exp[11:0];
  endtask

  task automatic full_frame(input string tag);
    logic [15:0] word;
    logic [15:0] exp;
    int          d0;
    d0 = done_seen;
    next_expected(exp);
    shift_bits(16, word);
    check_val({tag, "_word"}, {16'd0, word}, {16'd0, exp});
    check_val({tag, "_oe_off"}, {31'd0, spi_miso_oe_o}, 32'd0);
    check_val({tag, "_done"}, done_seen - d0, 32'd1);
    mdl_cnt++;
    check_val({tag, "_cnt"}, {16'd0, frame_cnt_o}, {16'd0, mdl_cnt});
    spi_ss_i = 1'b1;
    wait_clk(HALF);
    check_val({tag, "_level"}, {28'd0, fifo_level_o}, exp_q.size());
    check_val({tag, "_unr"}, {31'd0, underrun_o}, {31'd0, mdl_unr});
    $display("frame %s word=0x%04h exp=0x%04h", tag, word, exp);
  endtask

  initial begin
    logic [15:0] word;
    logic [15:0] exp;
    int          a0;

    // Reset state
    wait_clk(4);
    check_val("rst_level", {28'd0, fifo_level_o}, 32'd0);
    check_val("rst_full", {31'd0, fifo_full_o}, 32'd0);
    check_val("rst_oe", {31'd0, spi_miso_oe_o}, 32'd0);
    check_val("rst_miso", {31'd0, spi_miso_o}, 32'd0);
    check_val("rst_cnt", {16'd0, frame_cnt_o}, 32'd0);
    check_val("rst_flags", {28'd0, overflow_o, underrun_o, frame_done_o, frame_abort_o}, 32'd0);
    rst_i = 1'b1;
    enable_i = 1'b1;
    wait_clk(4);

    // Single sample
    push_sample(12'hABC);
    full_frame("abc");

    // Two queued samples
    push_sample(12'h123);
    push_sample(12'hFFF);
    check_val("two_level", {28'd0, fifo_level_o}, 32'd2);
    full_frame("s123");
    full_frame("sfff");

    // Empty FIFO replays last sample
    full_frame("under");
    clear_status();
    check_val("unr_clr", {31'd0, underrun_o}, {31'd0, mdl_unr});

    // Overflow: nine pushes into eight slots
    for (int i = 1; i <= 9; i++) push_sample(12'(i));
    check_val("ovf_full", {31'd0, fifo_full_o}, 32'd1);
    check_val("ovf_level", {28'd0, fifo_level_o}, 32'd8);
    check_val("ovf_flag", {31'd0, overflow_o}, {31'd0, mdl_ovf});
    for (int i = 1; i <= 8; i++) full_frame($sformatf("ovf%0d", i));

    // Abort after 7 SCLKs
    push_sample(12'h555);
    push_sample(12'h0AA);
    a0 = abort_seen;
    next_expected(exp);
    shift_bits(7, word);
    spi_ss_i = 1'b1;
    wait_clk(HALF);
    check_val("abort_bits", {25'd0, word[6:0]}, {25'd0, exp[15:9]});
    check_val("abort_pulse", abort_seen - a0, 32'd1);
    check_val("abort_cnt", {16'd0, frame_cnt_o}, {16'd0, mdl_cnt});
    check_val("abort_oe", {31'd0, spi_miso_oe_o}, 32'd0);
    $display("abort word7=0x%02h exp=0x%02h", word[6:0], exp[15:9]);
    full_frame("after_abort");

    // Disabled: CSn low starts nothing, pushes still land
    enable_i = 1'b0;
    push_sample(12'h321);
    spi_ss_i = 1'b0;
    wait_clk(2 * HALF);
    check_val("dis_oe", {31'd0, spi_miso_oe_o}, 32'd0);
    check_val("dis_level", {28'd0, fifo_level_o}, exp_q.size());
    spi_ss_i = 1'b1;
    wait_clk(HALF);
    enable_i = 1'b1;
    full_frame("after_dis");

    // Reset mid-frame, overflow still sticky from earlier
    check_val("pre_rst_ovf", {31'd0, overflow_o}, {31'd0, mdl_ovf});
    push_sample(12'h777);
    next_expected(exp);
    shift_bits(5, word);
    rst_i = 1'b0;
    spi_ss_i = 1'b1;
    wait_clk(1);
    check_val("mrst_oe", {31'd0, spi_miso_oe_o}, 32'd0);
    check_val("mrst_level", {28'd0, fifo_level_o}, 32'd0);
    check_val("mrst_cnt", {16'd0, frame_cnt_o}, 32'd0);
    check_val("mrst_flags", {28'd0, overflow_o, underrun_o, frame_done_o, frame_abort_o}, 32'd0);
    wait_clk(2);
    rst_i = 1'b1;
    exp_q.delete();
    mdl_last = '0;
    mdl_cnt  = '0;
    mdl_ovf  = 1'b0;
    mdl_unr  = 1'b0;
    wait_clk(4);
    full_frame("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
